// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory request/ack handshake (IDLE/REQ/DONE) and the MEM/WB register.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of masking low bits.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] MEM_ALU_OUT,
  input  logic [31:0] MEM_rs2,
  input  logic [4:0]  MEM_rd_ind,
  input  logic        MEM_rd_indzero,
  input  logic        MEM_regwrite,
  input  logic        MEM_memread,
  input  logic        MEM_memwrite,
  input  logic [2:0]  MEM_funct3,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic [31:0] WB_data,
  output logic [4:0]  WB_rd_ind,
  output logic        WB_rd_indzero,
  output logic        WB_regwrite,
  output logic        misalign_err
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e      r_state, w_state_next;
  logic        r_req, r_we;
  logic [31:0] r_addr, r_wdata, r_load;
  logic [3:0]  r_be;
  logic [31:0] r_wb_data;
  logic [4:0]  r_wb_rd_ind;
  logic        r_wb_rd_indzero, r_wb_regwrite;

  logic        w_access, w_is_read, w_aligned, w_start, w_trap, w_ack;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_shifted, w_load;

  assign w_access  = MEM_memread | MEM_memwrite;
  // A read+write combination is a store, so it never writes back loaded data.
  assign w_is_read = MEM_memread & ~MEM_memwrite;

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_aligned = ~(((MEM_funct3[1:0] == 2'b01) & MEM_ALU_OUT[0]) |
                       (MEM_funct3[1] & (|MEM_ALU_OUT[1:0])));
`else
  assign w_aligned = 1'b1;
`endif

  assign w_start = (r_state == StIdle) & w_access & w_aligned;
  assign w_trap  = (r_state == StIdle) & w_access & ~w_aligned;
  assign w_ack   = (r_state == StReq) & dmem_ack;
  assign stall   = w_start | (r_state == StReq);

  // Lane offset with the bits a half/word access cannot use dropped.
  always_comb begin
    w_off = MEM_ALU_OUT[1:0];
    case (MEM_funct3[1:0])
      2'b00:   w_off = MEM_ALU_OUT[1:0];
      2'b01:   w_off = {MEM_ALU_OUT[1], 1'b0};
      default: w_off = 2'b00;
    endcase
  end

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = MEM_rs2;
    case (MEM_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{MEM_rs2[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << w_off;
        w_wdata = {2{MEM_rs2[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_shifted = dmem_rdata >> {w_off, 3'b000};

  always_comb begin
    w_load = w_shifted;
    case (MEM_funct3[1:0])
      2'b00:   w_load = {{24{w_shifted[7] & ~MEM_funct3[2]}}, w_shifted[7:0]};
      2'b01:   w_load = {{16{w_shifted[15] & ~MEM_funct3[2]}}, w_shifted[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_start) w_state_next = StReq;
      StReq:   if (dmem_ack) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= StIdle;
      r_req           <= 1'b0;
      r_we            <= 1'b0;
      r_addr          <= '0;
      r_wdata         <= '0;
      r_be            <= '0;
      r_load          <= '0;
      r_wb_data       <= '0;
      r_wb_rd_ind     <= '0;
      r_wb_rd_indzero <= 1'b0;
      r_wb_regwrite   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_start) begin
        r_req   <= 1'b1;
        r_we    <= MEM_memwrite;
        r_addr  <= {MEM_ALU_OUT[31:2], 2'b00};
        r_be    <= w_be;
        r_wdata <= w_wdata;
      end else if (w_ack) begin
        r_req <= 1'b0;
      end
      if (w_ack) r_load <= w_load;
      // Stall and trapped accesses both retire as a bubble with the other fields held.
      if (stall || w_trap) begin
        r_wb_regwrite <= 1'b0;
      end else begin
        r_wb_data       <= w_is_read ? r_load : MEM_ALU_OUT;
        r_wb_rd_ind     <= MEM_rd_ind;
        r_wb_rd_indzero <= MEM_rd_indzero;
        r_wb_regwrite   <= MEM_regwrite;
      end
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic r_misalign;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_misalign <= 1'b0;
    end else if (w_trap) begin
      r_misalign <= 1'b1;
    end
  end

  assign misalign_err = r_misalign;
`else
  assign misalign_err = 1'b0;
`endif

  assign dmem_req      = r_req;
  assign dmem_we       = r_we;
  assign dmem_addr     = r_addr;
  assign dmem_wdata    = r_wdata;
  assign dmem_be       = r_be;
  assign WB_data       = r_wb_data;
  assign WB_rd_ind     = r_wb_rd_ind;
  assign WB_rd_indzero = r_wb_rd_indzero;
  assign WB_regwrite   = r_wb_regwrite;

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  in  1  rising-edge clock; the single clock domain.
REQ-002 rst  in  1  asynchronous, active-low reset.
REQ-003 MEM_ALU_OUT  in  32  effective address, or the result for non-memory instructions.
REQ-004 MEM_rs2  in  32  store data.
REQ-005 MEM_rd_ind  in  5  destination register index.
REQ-006 MEM_rd_indzero  in  1  destination index is x0.
REQ-007 MEM_regwrite, MEM_memread, MEM_memwrite  in  1 each  control bits from the EX/MEM buffer.
REQ-008 MEM_funct3  in  3  access size and sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-009 dmem_req  out  1  data-memory request, registered.
REQ-010 dmem_we  out  1  1 = write request.
REQ-011 dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
REQ-012 dmem_wdata  out  32  store data lane-shifted to the addressed byte.
REQ-013 dmem_be  out  4  byte enables.
REQ-014 dmem_ack  in  1  one-cycle completion pulse from the data memory.
REQ-015 dmem_rdata  in  32  read word, valid while dmem_ack=1.
REQ-016 stall  out  1  freezes the upstream pipeline (PC, IF/ID, ID/EX, EX/MEM).
REQ-017 WB_data, WB_rd_ind, WB_rd_indzero, WB_regwrite  out  32/5/1/1  MEM/WB register.
REQ-018 misalign_err  out  1  sticky misaligned-access flag.

Function
REQ-019 The block SHALL define access = MEM_memread|MEM_memwrite.
REQ-020 The FSM SHALL have three states: IDLE, REQ and DONE.
REQ-021 IDLE SHALL go to REQ when access=1 and the address is aligned; otherwise it SHALL stay in IDLE.
REQ-022 REQ SHALL go to DONE on dmem_ack=1 and SHALL stay in REQ while dmem_ack=0.
REQ-023 DONE SHALL go to IDLE unconditionally.
REQ-024 stall SHALL be combinational and equal (IDLE & access & aligned) | REQ.
REQ-025 stall SHALL be 0 in DONE.
REQ-026 On the IDLE->REQ edge, the block SHALL register dmem_addr, dmem_we, dmem_be and dmem_wdata, and these SHALL stay stable until ack.
REQ-027 dmem_req SHALL be 1 exactly while in REQ.
REQ-028 The block SHALL derive byte enables from addr[1:0]: byte 0001<<a, half 0011<<a, word 1111.
REQ-029 Store data SHALL be replicated per lane: byte {4{rs2[7:0]}}, half {2{rs2[15:0]}}.
REQ-030 On ack of a read, the block SHALL capture the addressed byte or half from dmem_rdata, sign- or zero-extended per funct3.
REQ-031 While stall=1, the WB register SHALL load a bubble: WB_regwrite=0, other WB fields held.
REQ-032 When stall=0, the WB register SHALL load on the clock edge: WB_data = loaded value if memread, else MEM_ALU_OUT; the other WB fields SHALL be copied from the inputs.
REQ-033 A non-memory instruction SHALL take one cycle: no stall, WB valid on the next edge.
REQ-034 A memory access SHALL take ack_latency+2 cycles of stall-free completion; minimum total 3 cycles with ack in the first REQ cycle.
REQ-035 If dmem_ack=1 in IDLE or DONE, the block SHALL ignore it.
REQ-036 The block SHALL treat MEM_memread and MEM_memwrite both set as a write.

Reset
REQ-037 On rst=0, the block SHALL asynchronously force state IDLE and set every output register to 0: dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, WB_*, misalign_err.
REQ-038 A reset during REQ SHALL abandon the request, with no retry after release.
REQ-039 After rst returns to 1, stall SHALL follow REQ-024 in the same cycle.

Configuration
REQ-040 The macro MEM_MISALIGN_TRAP_EN SHALL control misaligned-access trapping.
REQ-041 With MEM_MISALIGN_TRAP_EN defined, a misaligned access (half with addr[0]=1, or word with addr[1:0]!=0) SHALL issue no request, SHALL not stall, SHALL write a bubble to WB, and SHALL set misalign_err until reset.
REQ-042 Without MEM_MISALIGN_TRAP_EN, the block SHALL treat every access as aligned by ignoring the offending low address bits (word addr[1:0], half addr[0]), and misalign_err SHALL be tied to 0.

Verification
REQ-043 Reset then ADD result 0x0000_0055 to rd=5, regwrite=1 -> next edge WB_data=0x55, WB_rd_ind=5, WB_regwrite=1; stall never 1.
REQ-044 SB rs2=0x1234_56AB at addr 0x102, ack after 2 cycles -> dmem_be=0100, dmem_wdata=0xABABABAB, dmem_addr=0x100; stall high for 3 cycles; then WB_regwrite=0.
REQ-045 LB at addr 0x3 with rdata=0x80xx_xxxx -> WB_data=0xFFFF_FF80; the same case as LBU -> 0x0000_0080.
REQ-046 LH at addr 0x2 with rdata=0x7FFE_0000 -> WB_data=0x0000_7FFE; WB_regwrite high for exactly one cycle.
REQ-047 Drive rst=0 mid-REQ -> dmem_req=0 immediately; after release, no ack is required and the block stays in IDLE.
REQ-048 With MEM_MISALIGN_TRAP_EN defined, LW at 0x6 -> dmem_req stays 0, misalign_err=1 sticky, WB_regwrite=0; without the macro, dmem_addr=0x4 and the load completes.
